// File: rtl/sdpath_pkg.sv
// -----------------------------------------------------------------------------
// sdpath_pkg
// Shared definitions for the sdpath_m single-cycle datapath:
//   - ALU operation encodings (alu_op_e)
//   - write-back source encodings (wb_sel_e)
//   - next-PC source encodings (npc_sel_e)
//   - link register index and the 16->32 sign-extension helper
// -----------------------------------------------------------------------------
package sdpath_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_LUI = 2'b10,
    WB_PC4 = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BEQ = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  localparam logic [4:0] LINK_REG = 5'd31;

  // Sign-extend a 16-bit immediate to 32 bits.
  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/sdpath_regfile.sv
// -----------------------------------------------------------------------------
// sdpath_regfile
// 32 x 32-bit register file, two asynchronous read ports and one synchronous
// write port. Register 0 is hardwired to zero. Asynchronous active-low clear.
// Optional third read port when SDPATH_DEBUG_EN is defined.
// Ports:
//   clk      : clock, write on rising edge
//   rst_n    : asynchronous active-low clear of all registers
//   ra1_i    : read address 1     -> rd1_o
//   ra2_i    : read address 2     -> rd2_o
//   we_i     : write enable
//   wa_i     : write address
//   wd_i     : write data
//   ra3_i    : debug read address -> rd3_o (SDPATH_DEBUG_EN only)
// -----------------------------------------------------------------------------
module sdpath_regfile
  import sdpath_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
`ifdef SDPATH_DEBUG_EN
  ,
  input  logic [4:0]  ra3_i,
  output logic [31:0] rd3_o
`endif
);

  logic [31:0] regs_q [32];

  // Read with register 0 forced to zero regardless of storage contents.
  function automatic logic [31:0] rd_port(input logic [4:0] addr,
                                          input logic [31:0] val);
    if (addr == 5'd0) begin
      return 32'd0;
    end else begin
      return val;
    end
  endfunction

  // Register storage: async clear, write on clock edge, r0 writes dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end else begin
      regs_q[wa_i] <= regs_q[wa_i];
    end
  end

  assign rd1_o = rd_port(ra1_i, regs_q[ra1_i]);
  assign rd2_o = rd_port(ra2_i, regs_q[ra2_i]);
`ifdef SDPATH_DEBUG_EN
  assign rd3_o = rd_port(ra3_i, regs_q[ra3_i]);
`endif

endmodule

// File: rtl/sdpath_m.sv
// -----------------------------------------------------------------------------
// sdpath_m
// Single-cycle MIPS-style datapath: PC register, register file, ALU, sign
// extension and the write-back / ALU-operand / next-PC multiplexers.
// All outputs are combinational from the current PC, register file and inputs.
// Configuration macro: SDPATH_DEBUG_EN adds Debug_addr/Debug_data, a third
// asynchronous register-file read port.
// Ports:
//   clk          : clock
//   rst          : asynchronous active-low reset (PC <- RESET_PC, regs <- 0)
//   inst_field   : instruction[25:0] (rs, rt, rd, imm, target)
//   ALU_Control  : ALU operation select
//   ALUSrc_B     : 0 = rt data, 1 = sign-extended imm
//   RegDst       : write address 0 = rt, 1 = rd
//   RegWrite     : register write enable
//   Jal          : link write (address 31, data PC+4)
//   DatatoReg    : write-back source select
//   Branch       : next-PC source select
//   Data_in      : load data
//   Data_out     : rt read data (store data)
//   ALU_out      : ALU result
//   PC_out       : current PC
//   zero         : ALU_out == 0
//   overflow     : signed overflow of add/sub
// -----------------------------------------------------------------------------
module sdpath_m
  import sdpath_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [25:0] inst_field,
  input  logic [2:0]  ALU_Control,
  input  logic        ALUSrc_B,
  input  logic        RegDst,
  input  logic        RegWrite,
  input  logic        Jal,
  input  logic [1:0]  DatatoReg,
  input  logic [1:0]  Branch,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic [31:0] ALU_out,
  output logic [31:0] PC_out,
  output logic        zero,
  output logic        overflow
`ifdef SDPATH_DEBUG_EN
  ,
  input  logic [4:0]  Debug_addr,
  output logic [31:0] Debug_data
`endif
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [15:0] imm_s;
  logic [31:0] imm_ext_s;
  logic [31:0] pc_plus4_s;

  logic [31:0] rs_data_s;
  logic [31:0] rt_data_s;
  logic [31:0] alu_b_s;
  logic [31:0] add_s;
  logic [31:0] sub_s;
  logic [31:0] alu_res_s;
  logic        ovf_s;
  logic        zero_s;

  logic [4:0]  wa_s;
  logic [31:0] wd_s;

  assign rs_s       = inst_field[25:21];
  assign rt_s       = inst_field[20:16];
  assign rd_s       = inst_field[15:11];
  assign imm_s      = inst_field[15:0];
  assign imm_ext_s  = sign_ext16(imm_s);
  assign pc_plus4_s = pc_q + 32'd4;

  sdpath_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst),
    .ra1_i (rs_s),
    .ra2_i (rt_s),
    .we_i  (RegWrite),
    .wa_i  (wa_s),
    .wd_i  (wd_s),
    .rd1_o (rs_data_s),
    .rd2_o (rt_data_s)
`ifdef SDPATH_DEBUG_EN
    ,
    .ra3_i (Debug_addr),
    .rd3_o (Debug_data)
`endif
  );

  assign alu_b_s = ALUSrc_B ? imm_ext_s : rt_data_s;
  assign add_s   = rs_data_s + alu_b_s;
  assign sub_s   = rs_data_s - alu_b_s;

  // ALU result and signed overflow (only add/sub can flag overflow).
  always_comb begin
    alu_res_s = 32'd0;
    ovf_s     = 1'b0;
    case (alu_op_e'(ALU_Control))
      ALU_AND: alu_res_s = rs_data_s & alu_b_s;
      ALU_OR:  alu_res_s = rs_data_s | alu_b_s;
      ALU_ADD: begin
        alu_res_s = add_s;
        // Same-sign operands producing a differently signed sum.
        ovf_s = (rs_data_s[31] == alu_b_s[31]) && (add_s[31] != rs_data_s[31]);
      end
      ALU_XOR: alu_res_s = rs_data_s ^ alu_b_s;
      ALU_NOR: alu_res_s = ~(rs_data_s | alu_b_s);
      ALU_SRL: alu_res_s = alu_b_s >> rs_data_s[4:0];
      ALU_SUB: begin
        alu_res_s = sub_s;
        // Opposite-sign operands where the difference flips sign relative to A.
        ovf_s = (rs_data_s[31] != alu_b_s[31]) && (sub_s[31] != rs_data_s[31]);
      end
      ALU_SLT: alu_res_s = {31'd0, ($signed(rs_data_s) < $signed(alu_b_s))};
      default: alu_res_s = 32'd0;
    endcase
  end

  assign zero_s = (alu_res_s == 32'd0);

  // Write-back address and data; Jal overrides both with the link values.
  always_comb begin
    wa_s = rt_s;
    wd_s = alu_res_s;
    if (Jal) begin
      wa_s = LINK_REG;
      wd_s = pc_plus4_s;
    end else begin
      wa_s = RegDst ? rd_s : rt_s;
      case (wb_sel_e'(DatatoReg))
        WB_ALU:  wd_s = alu_res_s;
        WB_MEM:  wd_s = Data_in;
        WB_LUI:  wd_s = {imm_s, 16'h0000};
        WB_PC4:  wd_s = pc_plus4_s;
        default: wd_s = alu_res_s;
      endcase
    end
  end

  // Next-PC selection: sequential, taken-on-zero branch, jump, register jump.
  always_comb begin
    pc_d = pc_plus4_s;
    case (npc_sel_e'(Branch))
      NPC_SEQ: pc_d = pc_plus4_s;
      NPC_BEQ: begin
        if (zero_s) begin
          pc_d = pc_plus4_s + {imm_ext_s[29:0], 2'b00};
        end else begin
          pc_d = pc_plus4_s;
        end
      end
      NPC_J:   pc_d = {pc_plus4_s[31:28], inst_field, 2'b00};
      NPC_JR:  pc_d = rs_data_s;
      default: pc_d = pc_plus4_s;
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign Data_out = rt_data_s;
  assign ALU_out  = alu_res_s;
  assign PC_out   = pc_q;
  assign zero     = zero_s;
  assign overflow = ovf_s;

endmodule

// File: tb/tb_sdpath_m.sv
// -----------------------------------------------------------------------------
// tb_sdpath_m
// Self-checking bench for sdpath_m: directed scenarios with literal
// expectations, then randomized stimulus compared every cycle against a
// behavioural model of the datapath held in the bench.
// -----------------------------------------------------------------------------
module tb_sdpath_m;

  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] inst_field;
  logic [2:0]  ALU_Control;
  logic        ALUSrc_B;
  logic        RegDst;
  logic        RegWrite;
  logic        Jal;
  logic [1:0]  DatatoReg;
  logic [1:0]  Branch;
  logic [31:0] Data_in;
  logic [31:0] Data_out;
  logic [31:0] ALU_out;
  logic [31:0] PC_out;
  logic        zero;
  logic        overflow;
`ifdef SDPATH_DEBUG_EN
  logic [4:0]  Debug_addr;
  logic [31:0] Debug_data;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  sdpath_m #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_field  (inst_field),
    .ALU_Control (ALU_Control),
    .ALUSrc_B    (ALUSrc_B),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .Jal         (Jal),
    .DatatoReg   (DatatoReg),
    .Branch      (Branch),
    .Data_in     (Data_in),
    .Data_out    (Data_out),
    .ALU_out     (ALU_out),
    .PC_out      (PC_out),
    .zero        (zero),
    .overflow    (overflow)
`ifdef SDPATH_DEBUG_EN
    ,
    .Debug_addr  (Debug_addr),
    .Debug_data  (Debug_data)
`endif
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] dout;
    logic [31:0] alu;
    logic [31:0] npc;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        zero;
    logic        ovf;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic [31:0] m_pc;
  logic [31:0] m_regs [32];

  function automatic exp_t model_eval();
    exp_t        e;
    logic [31:0] a, b, simm, seq;
    longint      sa, sb, r;
    int          sh;
    a    = m_regs[inst_field[25:21]];
    simm = 32'($signed(inst_field[15:0]));
    b    = ALUSrc_B ? simm : m_regs[inst_field[20:16]];
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    e    = '0;
    e.dout = m_regs[inst_field[20:16]];
    case (ALU_Control)
      3'd0: e.alu = a & b;
      3'd1: e.alu = a | b;
      3'd2: begin
        r = sa + sb;
        e.alu = r[31:0];
        e.ovf = (r > SMAX) || (r < SMIN);
      end
      3'd3: e.alu = a ^ b;
      3'd4: e.alu = ~(a | b);
      3'd5: begin
        sh = int'(a % 32'd32);
        e.alu = b >> sh;
      end
      3'd6: begin
        r = sa - sb;
        e.alu = r[31:0];
        e.ovf = (r > SMAX) || (r < SMIN);
      end
      default: e.alu = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    e.zero = (e.alu == 32'd0);
    seq = m_pc + 32'd4;
    case (Branch)
      2'd0: e.npc = seq;
      2'd1: e.npc = e.zero ? seq + simm * 32'd4 : seq;
      2'd2: e.npc = (seq & 32'hF000_0000) + 32'(inst_field) * 32'd4;
      default: e.npc = a;
    endcase
    if (Jal) begin
      e.wa = 5'd31;
      e.wd = seq;
    end else begin
      e.wa = RegDst ? inst_field[15:11] : inst_field[20:16];
      case (DatatoReg)
        2'd0: e.wd = e.alu;
        2'd1: e.wd = Data_in;
        2'd2: e.wd = 32'(inst_field[15:0]) * 32'd65536;
        default: e.wd = seq;
      endcase
    end
    return e;
  endfunction

  // Model state advance on each clock edge, cleared by reset.
  always @(posedge clk or negedge rst) begin
    exp_t e;
    if (!rst) begin
      m_pc <= 32'h0000_0000;
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
    end else begin
      e = model_eval();
      if (RegWrite && (e.wa != 5'd0)) m_regs[e.wa] <= e.wd;
      m_pc <= e.npc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    exp_t e;
    e = model_eval();
    check("cyc Data_out", Data_out, e.dout);
    check("cyc ALU_out", ALU_out, e.alu);
    check("cyc PC_out", PC_out, m_pc);
    check("cyc zero", {31'd0, zero}, {31'd0, e.zero});
    check("cyc overflow", {31'd0, overflow}, {31'd0, e.ovf});
`ifdef SDPATH_DEBUG_EN
    check("cyc Debug_data", Debug_data, m_regs[Debug_addr]);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic [2:0] op, input logic srcb, input logic regdst,
                     input logic regwr, input logic jal, input logic [1:0] d2r,
                     input logic [1:0] br);
    ALU_Control = op;
    ALUSrc_B    = srcb;
    RegDst      = regdst;
    RegWrite    = regwr;
    Jal         = jal;
    DatatoReg   = d2r;
    Branch      = br;
  endtask

  task automatic load(input logic [4:0] r, input logic [31:0] v);
    inst_field = {5'd0, r, 16'd0};
    Data_in    = v;
    ctl(3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    inst_field = 26'd0;
    Data_in = 32'd0;
`ifdef SDPATH_DEBUG_EN
    Debug_addr = 5'd0;
`endif
    ctl(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    #1 rst = 1'b0;

    // Reset behaviour and release
    repeat (3) @(posedge clk);
    #1;
    check("rst PC_out", PC_out, 32'h0);
    check("rst ALU_out", ALU_out, 32'h0);
    check("rst zero", {31'd0, zero}, 32'd1);
    rst = 1'b1;
    tick(); check("pc seq 4", PC_out, 32'd4);
    tick(); check("pc seq 8", PC_out, 32'd8);
    tick(); check("pc seq 12", PC_out, 32'd12);

    // Load then add
    load(5'd18, 32'd1);
    load(5'd19, 32'd1);
    inst_field = 26'b10010_10011_10001_00000_100000;
    ctl(3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    #1;
    check("add ALU_out", ALU_out, 32'd2);
    check("add overflow", {31'd0, overflow}, 32'd0);
    tick();
    inst_field = {5'd0, 5'd17, 16'd0};
    ctl(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    #1 check("r17 Data_out", Data_out, 32'd2);
    tick();

    // Overflow and sub
    load(5'd1, 32'h7FFF_FFFF);
    load(5'd2, 32'd1);
    inst_field = {5'd1, 5'd2, 16'd0};
    ctl(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    #1;
    check("ovf ALU_out", ALU_out, 32'h8000_0000);
    check("ovf overflow", {31'd0, overflow}, 32'd1);
    tick();
    inst_field = {5'd1, 5'd1, 16'd0};
    ctl(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    #1;
    check("sub ALU_out", ALU_out, 32'd0);
    check("sub zero", {31'd0, zero}, 32'd1);
    check("sub overflow", {31'd0, overflow}, 32'd0);
    tick();

    // lui / slt / srl
    inst_field = {5'd0, 5'd3, 16'h1234};
    ctl(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00);
    tick();
    inst_field = {5'd0, 5'd3, 16'd0};
    ctl(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    #1 check("lui r3", Data_out, 32'h1234_0000);
    tick();
    load(5'd4, 32'hFFFF_FFFF);
    inst_field = {5'd4, 5'd0, 16'd1};
    ctl(3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    #1 check("slt ALU_out", ALU_out, 32'd1);
    tick();
    load(5'd5, 32'd4);
    inst_field = {5'd5, 5'd0, 16'h0080};
    ctl(3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    #1 check("srl ALU_out", ALU_out, 32'd8);
    tick();

    // Branches
    load(5'd6, 32'h10);
    inst_field = {5'd6, 21'd0};
    ctl(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11);
    tick(); check("jr to 0x10", PC_out, 32'h10);
    inst_field = {5'd0, 5'd0, 16'hFFFF};
    ctl(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
    tick(); check("beq taken", PC_out, 32'h10);
    ctl(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
    tick(); check("beq not taken", PC_out, 32'h14);
    inst_field = 26'h40;
    ctl(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
    tick(); check("j target", PC_out, 32'h100);
    load(5'd7, 32'h200);
    inst_field = {5'd7, 21'd0};
    ctl(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11);
    tick(); check("jr to 0x200", PC_out, 32'h200);

    // Jal and r0 write
    load(5'd8, 32'h20);
    inst_field = {5'd8, 21'd0};
    ctl(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11);
    tick(); check("jr to 0x20", PC_out, 32'h20);
    inst_field = 26'h80;
    ctl(3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10);
    tick(); check("jal target", PC_out, 32'h200);
    inst_field = {5'd0, 5'd31, 16'd0};
    ctl(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    #1 check("jal link r31", Data_out, 32'h24);
    tick();
    inst_field = {5'd0, 5'd0, 16'd0};
    Data_in = 32'hFFFF_FFFF;
    ctl(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00);
    tick();
    ctl(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    #1 check("r0 stays 0", Data_out, 32'd0);
    tick();

    // Randomized traffic checked by the every-cycle comparator
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 59) != 0);
      inst_field  = 26'($urandom);
      ALU_Control = 3'($urandom);
      ALUSrc_B    = 1'($urandom);
      RegDst      = 1'($urandom);
      RegWrite    = ($urandom_range(0, 3) != 0);
      Jal         = ($urandom_range(0, 7) == 0);
      DatatoReg   = 2'($urandom);
      Branch      = 2'($urandom);
      Data_in     = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : 32'($urandom);
`ifdef SDPATH_DEBUG_EN
      Debug_addr  = 5'($urandom);
`endif
      tick();
    end
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
